evt_sram_bank_ctrl: RTL and testbench
=====================================

EVT_SRAM_BANK_CTRL -- requirements
Module: evt_sram_bank_ctrl

Parameters
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter NUM_WORDS, default 32, total words across all banks.
REQ-003 SHALL have parameter NUM_BANKS, default 2, power of two >= 1; NUM_WORDS SHALL be divisible by NUM_BANKS.
REQ-004 SHALL have parameter WAKE_CYCLES, default 4, range 1..255; cycles from power-request release to ready.
REQ-005 SHALL derive localparam ADDR_WIDTH = $clog2(NUM_WORDS) and BANK_BITS = $clog2(NUM_BANKS).

Interface
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_ni  in  1  asynchronous, active-low reset.
REQ-008 power_gate_i  in  1  request bank power-off; contents lost.
REQ-009 power_sleep_i  in  1  request bank retention sleep; contents kept.
REQ-010 rd_valid_i / rd_ready_o  in/out  1/1  read request handshake.
REQ-011 rd_addr_i  in  ADDR_WIDTH  read word address.
REQ-012 rdata_o / rdata_valid_o  out  DATA_WIDTH/1  read data and its valid strobe.
REQ-013 wr_valid_i / wr_ready_o  in/out  1/1  write request handshake.
REQ-014 wr_addr_i, wr_data_i  in  ADDR_WIDTH, DATA_WIDTH  write address and data; full-word writes.
REQ-015 busy_o  out  1  high whenever the FSM is not in ACTIVE.

Function
REQ-016 Banking: bank = addr[BANK_BITS-1:0], row = addr[ADDR_WIDTH-1:BANK_BITS], low-order interleaved.
- Each bank is one sne_sram instance: NUM_WORDS/NUM_BANKS words, 1-cycle read latency.
- With NUM_BANKS=1, the bank select is constant 0.
REQ-017 A transfer is accepted when valid && ready on a rising edge; rd_ready_o and wr_ready_o SHALL be 0 unless the FSM is ACTIVE and both power requests are low.
REQ-018 Read and write to different banks in the same cycle SHALL both be accepted.
REQ-019 Same-bank conflict:
- Exactly one request is accepted, chosen by the priority flag prio_q (0 = write wins, 1 = read wins).
- The loser's ready SHALL be 0 that cycle.
- prio_q SHALL toggle after every cycle in which a conflict occurred, so neither port starves beyond 1 cycle.
REQ-020 prio_q SHALL be unchanged in cycles without a same-bank conflict.
REQ-021 rdata_valid_o SHALL pulse high exactly 1 cycle after an accepted read, with rdata_o = SRAM content of that address.
REQ-022 rdata_o SHALL hold its last value until the next rdata_valid_o pulse.
REQ-023 A write accepted in cycle N SHALL be visible to a read accepted in cycle N+1 or later.
REQ-024 FSM states: ACTIVE, SLEEP, OFF, WAKE; reset state is ACTIVE.
REQ-025 Transitions out of ACTIVE:
- to OFF when power_gate_i = 1 (gate has priority over sleep);
- else to SLEEP when power_sleep_i = 1.
REQ-026 Transitions out of SLEEP and OFF:
- SLEEP -> OFF when power_gate_i = 1;
- SLEEP/OFF -> WAKE when both requests are 0; wake counter loads WAKE_CYCLES-1.
REQ-027 WAKE:
- decrements the counter each cycle and moves to ACTIVE in the cycle after the counter reads 0;
- any power request in WAKE SHALL return to SLEEP or OFF per REQ-025 priority.
REQ-028 Bank power_sleep pins SHALL be 1 in SLEEP; bank power_gate pins SHALL be 1 in OFF; both SHALL be 0 in ACTIVE and WAKE.
REQ-029 A read accepted in the last ACTIVE cycle SHALL still produce rdata_valid_o in the following cycle.
REQ-030 Reads after a return from OFF return unspecified data; reads after a return from SLEEP return retained data.

Reset
REQ-031 While rst_ni = 0:
- FSM = ACTIVE, prio_q = 0, wake counter = 0;
- rdata_o = 0, rdata_valid_o = 0, busy_o = 0;
- no SRAM request is issued.
REQ-032 Reset asserted mid-transfer SHALL drop any pending rdata_valid_o pulse; SRAM contents are not cleared by reset.

Verification
REQ-033 Write 0xA5 to addr 3, then read addr 3 -> rdata_o = 0xA5 with rdata_valid_o 1 cycle after read accept.
REQ-034 Same cycle, write addr 2 (bank 0) and read addr 5 (bank 1), NUM_BANKS = 2 -> both ready = 1; read data valid in the next cycle.
REQ-035 Continuous same-bank read addr 4 and write addr 6 for 4 cycles -> acceptance order W, R, W, R; prio_q toggles each cycle.
REQ-036 Assert power_sleep_i for 3 cycles, then release, WAKE_CYCLES = 4 ->
- readies are 0 from the first sleep cycle;
- busy_o = 1 until the 4th cycle after release;
- retained data reads back intact.
REQ-037 power_gate_i during WAKE -> FSM goes to OFF next cycle; the wake counter restarts on release.
REQ-038 rst_ni low the cycle after a read accept -> rdata_valid_o stays 0 and rdata_o = 0; FSM = ACTIVE after release.

Source files
------------

// File: rtl/evt_sram_bank_ctrl.sv
// Banked SRAM controller with low-order address interleaving, same-bank read/write
// arbitration and a sleep / power-off / wake sequencer shared by all banks.

module sne_sram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic                  power_sleep_i,
    input  logic                  power_gate_i
);
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Storage array and registered read port; no access while sleeping or gated
    always_ff @(posedge clk_i) begin
        if (req_i && !power_sleep_i && !power_gate_i) begin
            if (we_i) begin
                mem_r[addr_i] <= wdata_i;
            end else begin
                rdata_r <= mem_r[addr_i];
            end
        end
    end

    assign rdata_o = rdata_r;
endmodule

module evt_sram_bank_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_WORDS   = 32,
    parameter int NUM_BANKS   = 2,
    parameter int WAKE_CYCLES = 4,
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS),
    localparam int BANK_BITS  = $clog2(NUM_BANKS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  power_gate_i,
    input  logic                  power_sleep_i,
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  busy_o
);
    localparam int BSEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_W      = ADDR_WIDTH - BANK_BITS;
    localparam int BANK_WORDS = NUM_WORDS / NUM_BANKS;
    localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'b00,
        ST_SLEEP  = 2'b01,
        ST_OFF    = 2'b10,
        ST_WAKE   = 2'b11
    } state_t;

    state_t                state_r, state_s;
    logic [7:0]            wake_cnt_r, wake_cnt_s;
    logic                  prio_r;
    logic                  busy_r;
    logic                  rvalid_r;
    logic [BSEL_W-1:0]     rbank_r;
    logic [DATA_WIDTH-1:0] hold_r;

    logic [BSEL_W-1:0]     rd_bank_s, wr_bank_s;
    logic [ROW_W-1:0]      rd_row_s, wr_row_s;
    logic                  base_rdy_s, conflict_s, rd_fire_s, wr_fire_s;
    logic                  bank_sleep_s, bank_gate_s;
    logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];

    assign rd_row_s = rd_addr_i[ADDR_WIDTH-1:BANK_BITS];
    assign wr_row_s = wr_addr_i[ADDR_WIDTH-1:BANK_BITS];

    if (NUM_BANKS > 1) begin : g_bsel
        assign rd_bank_s = rd_addr_i[BANK_BITS-1:0];
        assign wr_bank_s = wr_addr_i[BANK_BITS-1:0];
    end else begin : g_bsel_one
        assign rd_bank_s = '0;
        assign wr_bank_s = '0;
    end

    // Handshake and same-bank arbitration: prio_r = 0 lets the write win
    always_comb begin
        base_rdy_s = rst_ni && (state_r == ST_ACTIVE) && !power_gate_i && !power_sleep_i;
        conflict_s = base_rdy_s && rd_valid_i && wr_valid_i && (rd_bank_s == wr_bank_s);
        rd_ready_o = base_rdy_s && !(conflict_s && !prio_r);
        wr_ready_o = base_rdy_s && !(conflict_s && prio_r);
        rd_fire_s  = rd_valid_i && rd_ready_o;
        wr_fire_s  = wr_valid_i && wr_ready_o;
    end

    // Power sequencer next state; gate request always dominates sleep
    always_comb begin
        state_s    = state_r;
        wake_cnt_s = wake_cnt_r;
        case (state_r)
            ST_ACTIVE: begin
                if (power_gate_i) begin
                    state_s = ST_OFF;
                end else if (power_sleep_i) begin
                    state_s = ST_SLEEP;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_SLEEP: begin
                if (power_gate_i) begin
                    state_s = ST_OFF;
                end else if (!power_sleep_i) begin
                    state_s    = ST_WAKE;
                    wake_cnt_s = WAKE_LOAD;
                end else begin
                    state_s = ST_SLEEP;
                end
            end
            ST_OFF: begin
                if (!power_gate_i && !power_sleep_i) begin
                    state_s    = ST_WAKE;
                    wake_cnt_s = WAKE_LOAD;
                end else begin
                    state_s = ST_OFF;
                end
            end
            ST_WAKE: begin
                if (power_gate_i) begin
                    state_s = ST_OFF;
                end else if (power_sleep_i) begin
                    state_s = ST_SLEEP;
                end else if (wake_cnt_r == 8'd0) begin
                    state_s = ST_ACTIVE;
                end else begin
                    wake_cnt_s = wake_cnt_r - 8'd1;
                end
            end
            default: begin
                state_s = ST_ACTIVE;
            end
        endcase
    end

    // Sequencer state, arbitration flag and registered busy flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_ACTIVE;
            wake_cnt_r <= 8'd0;
            prio_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            wake_cnt_r <= wake_cnt_s;
            busy_r     <= (state_s != ST_ACTIVE);
            if (conflict_s) begin
                prio_r <= !prio_r;
            end
        end
    end

    assign bank_sleep_s = (state_r == ST_SLEEP);
    assign bank_gate_s  = (state_r == ST_OFF);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic bank_rd_s, bank_wr_s;
        assign bank_rd_s = rd_fire_s && (rd_bank_s == BSEL_W'(b));
        assign bank_wr_s = wr_fire_s && (wr_bank_s == BSEL_W'(b));

        sne_sram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BANK_WORDS),
            .ADDR_W     (ROW_W)
        ) u_sram (
            .clk_i         (clk_i),
            .req_i         (bank_rd_s || bank_wr_s),
            .we_i          (bank_wr_s),
            .addr_i        (bank_wr_s ? wr_row_s : rd_row_s),
            .wdata_i       (wr_data_i),
            .rdata_o       (bank_q[b]),
            .power_sleep_i (bank_sleep_s),
            .power_gate_i  (bank_gate_s)
        );
    end

    // Read return tracking; hold_r keeps the last returned word between pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            rbank_r  <= '0;
            hold_r   <= '0;
        end else begin
            rvalid_r <= rd_fire_s;
            if (rd_fire_s) begin
                rbank_r <= rd_bank_s;
            end
            if (rvalid_r) begin
                hold_r <= bank_q[rbank_r];
            end
        end
    end

    assign rdata_o       = rvalid_r ? bank_q[rbank_r] : hold_r;
    assign rdata_valid_o = rvalid_r;
    assign busy_o        = busy_r;
endmodule

// File: tb/tb_evt_sram_bank_ctrl.sv
// Directed bench for evt_sram_bank_ctrl with default parameters (2 banks, WAKE_CYCLES = 4).

module tb_evt_sram_bank_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       power_gate, power_sleep;
    logic       rd_valid, rd_ready, rdata_valid;
    logic [4:0] rd_addr, wr_addr;
    logic [7:0] rdata, wr_data;
    logic       wr_valid, wr_ready, busy;

    int n_checks = 0;
    int n_pass   = 0;

    evt_sram_bank_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .power_gate_i  (power_gate),
        .power_sleep_i (power_sleep),
        .rd_valid_i    (rd_valid),
        .rd_ready_o    (rd_ready),
        .rd_addr_i     (rd_addr),
        .rdata_o       (rdata),
        .rdata_valid_o (rdata_valid),
        .wr_valid_i    (wr_valid),
        .wr_ready_o    (wr_ready),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        #2;
        check_eq("wr_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [7:0] exp);
        rd_valid = 1'b1;
        rd_addr  = a;
        #2;
        check_eq("rd_ready", 32'(rd_ready), 32'd1);
        tick();
        rd_valid = 1'b0;
        check_eq("rd_valid_pulse", 32'(rdata_valid), 32'd1);
        check_eq("rd_data", 32'(rdata), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; power_gate = 1'b0; power_sleep = 1'b0;
        rd_valid = 1'b1; rd_addr = 5'd3; wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;

        // Reset state, with a read request held during reset
        repeat (3) tick();
        check_eq("rst_valid", 32'(rdata_valid), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rd_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Basic write then read
        do_write(5'd3, 8'hA5);
        do_read(5'd3, 8'hA5);
        tick();
        check_eq("valid_one_cycle", 32'(rdata_valid), 32'd0);
        check_eq("rdata_hold", 32'(rdata), 32'hA5);

        // Different banks in the same cycle
        do_write(5'd5, 8'h77);
        do_write(5'd4, 8'h44);
        rd_valid = 1'b1; rd_addr = 5'd5;
        wr_valid = 1'b1; wr_addr = 5'd2; wr_data = 8'h3C;
        #2;
        check_eq("dual_rd_ready", 32'(rd_ready), 32'd1);
        check_eq("dual_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        rd_valid = 1'b0; wr_valid = 1'b0;
        check_eq("dual_valid", 32'(rdata_valid), 32'd1);
        check_eq("dual_rdata", 32'(rdata), 32'h77);
        do_read(5'd2, 8'h3C);
        tick();

        // Same-bank conflict: acceptance alternates W, R, W, R
        rd_valid = 1'b1; rd_addr = 5'd4;
        wr_valid = 1'b1; wr_addr = 5'd6;
        for (int k = 0; k < 4; k++) begin
            wr_data = 8'h10 + 8'(k);
            #2;
            check_eq("conf_wr_ready", 32'(wr_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("conf_rd_ready", 32'(rd_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            check_eq("conf_rvalid", 32'(rdata_valid), (k % 2 == 1) ? 32'd1 : 32'd0);
            check_eq("conf_rdata", 32'(rdata), (k == 0) ? 32'h3C : 32'h44);
        end
        rd_valid = 1'b0; wr_valid = 1'b0;
        do_read(5'd6, 8'h12);
        tick();

        // Sleep for 3 cycles, release, wake for WAKE_CYCLES, read retained data
        rd_valid = 1'b1; rd_addr = 5'd3; power_sleep = 1'b1;
        #2;
        check_eq("sleep_rd_ready", 32'(rd_ready), 32'd0);
        tick();
        check_eq("sleep_busy", 32'(busy), 32'd1);
        tick();
        tick();
        power_sleep = 1'b0;
        #1;
        check_eq("release_busy", 32'(busy), 32'd1);
        check_eq("release_rd_ready", 32'(rd_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("wake_busy", 32'(busy), 32'd1);
        end
        tick();
        check_eq("active_busy", 32'(busy), 32'd0);
        #1;
        check_eq("active_rd_ready", 32'(rd_ready), 32'd1);
        tick();
        rd_valid = 1'b0;
        check_eq("retained_valid", 32'(rdata_valid), 32'd1);
        check_eq("retained_rdata", 32'(rdata), 32'hA5);
        tick();

        // Gate during WAKE goes to OFF, and the wake count restarts on release
        power_sleep = 1'b1;
        tick();
        power_sleep = 1'b0;
        tick();
        tick();
        power_gate = 1'b1;
        tick();
        check_eq("off_busy", 32'(busy), 32'd1);
        power_gate = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rewake_busy", 32'(busy), 32'd1);
        end
        tick();
        check_eq("rewake_active", 32'(busy), 32'd0);

        // Reset right after a read accept drops the pending pulse and clears prio
        do_write(5'd3, 8'hC3);
        rd_valid = 1'b1; rd_addr = 5'd4;
        wr_valid = 1'b1; wr_addr = 5'd6; wr_data = 8'h66;
        #2;
        check_eq("pre_rst_wr_win", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        rd_addr  = 5'd3;
        tick();
        rd_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_eq("rst_drop_valid", 32'(rdata_valid), 32'd0);
        check_eq("rst_drop_rdata", 32'(rdata), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        rd_valid = 1'b1; rd_addr = 5'd4;
        wr_valid = 1'b1; wr_addr = 5'd6; wr_data = 8'h67;
        #2;
        check_eq("post_rst_wr_win", 32'(wr_ready), 32'd1);
        check_eq("post_rst_rd_lose", 32'(rd_ready), 32'd0);
        tick();
        rd_valid = 1'b0; wr_valid = 1'b0;
        do_read(5'd3, 8'hC3);
        do_read(5'd6, 8'h67);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
